// File: rtl/pe_pkg.sv
// Shared types for the PE-side feeders.
package pe_pkg;

    typedef enum logic [1:0] {
        FD_IDLE = 2'd0,
        FD_RUN  = 2'd1,
        FD_DONE = 2'd2
    } feed_state_e;

endpackage

// File: rtl/pix_fifo.sv
// Small registered FIFO with wrap-bit pointers; no write-to-read bypass.
// Shared between the IF and weight feeders.
module pix_fifo #(
    parameter int W     = 17,
    parameter int Depth = 4
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic [W-1:0] i_wdata,
    input  logic         i_pop,
    output logic [W-1:0] o_rdata,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(Depth);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [Depth];
    logic [W-1:0] mem_d [Depth];
    logic         full, empty, push_ok, pop_ok;

    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        push_ok = i_push && !full && !i_clr;
        pop_ok  = i_pop && !empty && !i_clr;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        // Flush only rewinds pointers; stale entries are never visible.
        if (i_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q[AW-1:0]] = i_wdata;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign o_rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign o_full  = full;
    assign o_empty = empty;

endmodule

// File: rtl/if_pix_feeder.sv
// IF pixel feeder: buffers global-buffer pixels, tags zeros, drives the pad
// handshake and tracks row / pass boundaries for the PE controller.
module if_pix_feeder
    import pe_pkg::*;
#(
    parameter int DWd     = 16,
    parameter int Depth   = 4,
    parameter int ConfDWd = 4
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic               i_clr,
    input  logic [ConfDWd-1:0] i_if_len,
    input  logic [ConfDWd-1:0] i_row_num,
    input  logic [DWd-1:0]     i_gb_wdata,
    input  logic               i_gb_valid,
    output logic               o_gb_ready,
    output logic [DWd-1:0]     o_pix_wdata,
    output logic               o_pix_zero,
    output logic               o_pix_valid,
    input  logic               i_pix_ready,
    output logic               o_row_done,
    output logic               o_done
);

    localparam int CW = ConfDWd + 1;
    localparam int TW = 2 * CW;
    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] T_ONE = {{(TW-1){1'b0}}, 1'b1};

    feed_state_e   state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] rows_q, rows_d;
    logic [CW-1:0] pix_cnt_q, pix_cnt_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic [TW-1:0] push_cnt_q, push_cnt_d;
    logic [TW-1:0] total_q, total_d;
    logic          done_q, done_d;

    logic [CW-1:0] len_in, rows_in;
    logic [TW-1:0] total_in;
    logic          fifo_full, fifo_empty;
    logic [DWd:0]  fifo_head;
    logic          gb_ready, pix_valid, push, pop, row_end, pass_end;

    pix_fifo #(
        .W    (DWd + 1),
        .Depth(Depth)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_clr  (i_clr),
        .i_push (push),
        .i_wdata({(i_gb_wdata == '0), i_gb_wdata}),
        .i_pop  (pop),
        .o_rdata(fifo_head),
        .o_full (fifo_full),
        .o_empty(fifo_empty)
    );

    always_comb begin
        // A config of 0 encodes the full 2^ConfDWd length.
        len_in   = {(i_if_len == '0), i_if_len};
        rows_in  = {(i_row_num == '0), i_row_num};
        total_in = {{CW{1'b0}}, len_in} * {{CW{1'b0}}, rows_in};

        gb_ready  = (state_q == FD_RUN) && !fifo_full && (push_cnt_q != total_q);
        pix_valid = (state_q == FD_RUN) && !fifo_empty;
        push      = i_gb_valid && gb_ready && !i_clr;
        pop       = pix_valid && i_pix_ready && !i_clr;
        row_end   = pop && (pix_cnt_q == len_q - C_ONE);
        pass_end  = row_end && (row_cnt_q == rows_q - C_ONE);
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rows_d     = rows_q;
        total_d    = total_q;
        pix_cnt_d  = pix_cnt_q;
        row_cnt_d  = row_cnt_q;
        push_cnt_d = push_cnt_q;

        if (i_clr) begin
            state_d    = FD_IDLE;
            pix_cnt_d  = '0;
            row_cnt_d  = '0;
            push_cnt_d = '0;
        end else begin
            unique case (state_q)
                FD_IDLE, FD_DONE: begin
                    if (i_start) begin
                        state_d    = FD_RUN;
                        len_d      = len_in;
                        rows_d     = rows_in;
                        total_d    = total_in;
                        pix_cnt_d  = '0;
                        row_cnt_d  = '0;
                        push_cnt_d = '0;
                    end
                end
                FD_RUN: begin
                    if (push) begin
                        push_cnt_d = push_cnt_q + T_ONE;
                    end
                    if (pass_end) begin
                        state_d   = FD_DONE;
                        pix_cnt_d = '0;
                    end else if (row_end) begin
                        pix_cnt_d = '0;
                        row_cnt_d = row_cnt_q + C_ONE;
                    end else if (pop) begin
                        pix_cnt_d = pix_cnt_q + C_ONE;
                    end
                end
                default: state_d = FD_IDLE;
            endcase
        end

        done_d = (state_d == FD_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= FD_IDLE;
            len_q      <= '0;
            rows_q     <= '0;
            total_q    <= '0;
            pix_cnt_q  <= '0;
            row_cnt_q  <= '0;
            push_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rows_q     <= rows_d;
            total_q    <= total_d;
            pix_cnt_q  <= pix_cnt_d;
            row_cnt_q  <= row_cnt_d;
            push_cnt_q <= push_cnt_d;
            done_q     <= done_d;
        end
    end

    assign o_gb_ready  = gb_ready;
    assign o_pix_valid = pix_valid;
    assign o_pix_wdata = pix_valid ? fifo_head[DWd-1:0] : '0;
    assign o_pix_zero  = pix_valid && fifo_head[DWd];
    assign o_row_done  = row_end;
    assign o_done      = done_q;

endmodule
